commit_checker: RTL

Self-checking consumer of the CPU's in-order commit stream (`commit`, `commit_pc`, `commit_pre_pc`), instantiated beside the CPU in the testbench or FPGA top. It checks that every retired instruction's PC equals the next-PC announced by the previous commit. It counts retired instructions and cycles, and detects program halt (a self-jump) and pipeline deadlock (watchdog). It reports pass/fail through sticky status registers.

---
 rtl/commit_checker_pkg.sv | 10 +
 rtl/commit_checker_sat_counter.sv | 25 ++
 rtl/commit_checker.sv | 139 +++++++++++++
 3 files changed

// File: rtl/commit_checker_pkg.sv
// Shared constants for the commit-stream checker: default PC width and error codes.
package commit_checker_pkg;

  localparam int PC_WIDTH_DEF = 32;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/commit_checker_sat_counter.sv
// Up-counter with synchronous reset, synchronous clear and enable; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  // count register: clear wins over enable, increment stops at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {WIDTH{1'b0}};
    end else if (clr) begin
      cnt <= {WIDTH{1'b0}};
    end else if (en && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/commit_checker.sv
// Checks the in-order commit stream for PC continuity, detects self-jump halt
// and commit starvation, and reports sticky pass/fail status.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
  parameter int                  TIMEOUT   = 1024,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 commit_i,
  input  logic [PC_WIDTH-1:0]  commit_pc_i,
  input  logic [PC_WIDTH-1:0]  commit_pre_pc_i,
  output logic                 done_o,
  output logic                 error_o,
  output logic [1:0]           err_code_o,
  output logic [PC_WIDTH-1:0]  err_pc_o,
  output logic [PC_WIDTH-1:0]  exp_pc_o,
  output logic [CNT_WIDTH-1:0] instret_o,
  output logic [CNT_WIDTH-1:0] cycle_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic                done_r;
  logic                error_r;
  logic [1:0]          err_code_r;
  logic [PC_WIDTH-1:0] err_pc_r;
  logic [PC_WIDTH-1:0] exp_pc_r;
  logic [IDLE_W-1:0]   idle_cnt_s;
  logic                in_run_s;
  logic                pc_match_s;
  logic                accept_s;
  logic                mismatch_s;
  logic                halt_s;
  logic                timeout_s;

  // commit classification; a mismatch masks halt detection
  always_comb begin
    in_run_s   = (state_r == ST_RUN);
    pc_match_s = (commit_pc_i == exp_pc_r);
    accept_s   = in_run_s & commit_i & pc_match_s;
    mismatch_s = in_run_s & commit_i & ~pc_match_s;
    halt_s     = accept_s & (commit_pre_pc_i == commit_pc_i);
    timeout_s  = in_run_s & ~commit_i & (idle_cnt_s == IDLE_W'(TIMEOUT - 1));
  end

  // next-state logic; DONE and ERR only leave through reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mismatch_s || timeout_s) begin
          state_nxt_s = ST_ERR;
        end else if (halt_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      ST_ERR:  state_nxt_s = ST_ERR;
      default: state_nxt_s = ST_ERR;
    endcase
  end

  // state, sticky status and PC tracking registers
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_r    <= ST_RUN;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
      err_pc_r   <= {PC_WIDTH{1'b0}};
      exp_pc_r   <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
      error_r <= (state_nxt_s == ST_ERR);
      if (mismatch_s) begin
        err_code_r <= ERR_MISMATCH;
        err_pc_r   <= commit_pc_i;
      end else if (timeout_s) begin
        err_code_r <= ERR_TIMEOUT;
        err_pc_r   <= exp_pc_r;
      end else begin
        err_code_r <= err_code_r;
        err_pc_r   <= err_pc_r;
      end
      // on a halt pre_pc equals pc, so loading it leaves exp_pc unchanged
      if (accept_s) begin
        exp_pc_r <= commit_pre_pc_i;
      end else begin
        exp_pc_r <= exp_pc_r;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk (clk_i),
    .rst (rst),
    .clr (1'b0),
    .en  (accept_s),
    .cnt (instret_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk (clk_i),
    .rst (rst),
    .clr (1'b0),
    .en  (in_run_s),
    .cnt (cycle_o)
  );

  sat_counter #(.WIDTH(IDLE_W)) u_idle (
    .clk (clk_i),
    .rst (rst),
    .clr (in_run_s & commit_i),
    .en  (in_run_s & ~commit_i),
    .cnt (idle_cnt_s)
  );

  assign done_o     = done_r;
  assign error_o    = error_r;
  assign err_code_o = err_code_r;
  assign err_pc_o   = err_pc_r;
  assign exp_pc_o   = exp_pc_r;

endmodule
